imem_loader: RTL and testbench
==============================

# imem_loader

Program loader and run controller for the pipelined processor. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into instruction memory at addresses starting from 0. It holds the core in reset until loading completes, releases it, and then watches `isLastInstruction`. After a fixed drain it reports completion together with the run-cycle count.

## Interface
- `DEPTH`, 1024: instruction memory depth in words.
- `ADDR_W`, 10: memory address width; 2^ADDR_W == DEPTH.
- `DRAIN_CYCLES`, 4: cycles waited after `isLastInstruction` before DONE (≥1).
- `MAX_CYCLES`, 100000: RUN timeout in cycles.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request a load-and-run; sampled only in IDLE or DONE.
- `load_len` in ADDR_W+1: word count, legal 1..DEPTH; latched on accepted `start`.
- `in_valid` in 1: instruction word valid.
- `in_data` in 32: instruction word.
- `in_ready` out 1: loader accepts a word this cycle.
- `mem_we` out 1: instruction memory write enable.
- `mem_addr` out ADDR_W: write address.
- `mem_wdata` out 32: write data.
- `core_reset` out 1: active-high reset to the processor.
- `isLastInstruction` in 1: processor has retired its final instruction.
- `busy` out 1: state is LOAD, RELEASE, RUN or DRAIN.
- `done` out 1: run finished; held until the next accepted `start` or reset.
- `error` out 1: illegal `load_len` or RUN timeout; sticky until the next accepted `start` or reset.
- `cycle_count` out 32: number of cycles spent in RUN.

## Operation
- **Reset values:** state IDLE; `in_ready`, `mem_we`, `busy`, `done`, `error` = 0; `mem_addr`, `mem_wdata`, `cycle_count` = 0; `core_reset` = 1.
- **IDLE/DONE:**
  - `start`=1 with `load_len` of 0 or >DEPTH: set `error`=1 and clear `done`. The next state is IDLE in both cases.
  - `start`=1 with legal `load_len`: clear `done`, `error` and `cycle_count`, latch `load_len`, clear the word counter, and go to LOAD.
- **LOAD:**
  - `in_ready`=1.
  - Each cycle with `in_valid`&&`in_ready` accepts one word.
  - The k-th accepted word (0-based) is written on the next cycle: `mem_we`=1, `mem_addr`=k, `mem_wdata`=word.
  - When the accepted word is number `load_len`-1, go to RELEASE.
- **RELEASE:** exactly one cycle; `in_ready`=0; `core_reset` stays 1. The final write is performed here.
- **RUN:**
  - `core_reset`=0; `cycle_count` increments every RUN cycle.
  - `isLastInstruction`=1 moves the FSM to DRAIN and loads the drain counter with DRAIN_CYCLES.
  - If `cycle_count` reaches MAX_CYCLES-1 without `isLastInstruction`: set `error`=1 and go to DONE.
- **DRAIN:** `core_reset`=0; the drain counter decrements each cycle; when it hits 1, go to DONE.
- **DONE:** `core_reset`=1, `done`=1; `cycle_count` is frozen.
- **Ignored inputs:**
  - `start` in LOAD, RELEASE, RUN and DRAIN.
  - `isLastInstruction` outside RUN.
  - `in_valid` outside LOAD.
- **Address range:** `load_len`==DEPTH writes addresses 0..DEPTH-1; the counter never wraps inside a load.
- **Reset mid-operation:** immediately forces all reset values (`mem_we` drops, `core_reset` rises). The memory contents already written are left as they are.

## Timing
- All outputs are registered.
- Write latency: handshake at edge t produces `mem_we` high during cycle t+1.
- Back-to-back `in_valid` sustains one word per cycle with no bubbles.
- Last word accepted at cycle t:
  - RELEASE at t+1, which carries the last `mem_we`.
  - `core_reset` falls at t+2.
- `isLastInstruction` sampled high at cycle r gives DRAIN from r+1 and `done`=1 at r+1+DRAIN_CYCLES.
- `cycle_count` equals the number of cycles with state==RUN, including the cycle that samples `isLastInstruction`.
- `start` in IDLE: LOAD, with `in_ready`=1, on the next cycle. A word presented together with `start` is not accepted.

## Test plan
- **Reset:** apply reset, then release → IDLE outputs: `core_reset`=1, `in_ready`=0, `done`=0, `error`=0, `cycle_count`=0.
- **Basic load:** `load_len`=3, words 0xA0,0xB1,0xC2 back-to-back → writes (0,0xA0),(1,0xB1),(2,0xC2) on consecutive cycles; `core_reset` falls 2 cycles after the third accept.
- **Full run:** `isLastInstruction` pulsed after 10 RUN cycles with DRAIN_CYCLES=4 → `cycle_count`=10; `done`=1 exactly 4 cycles after the pulse; `core_reset`=1 again.
- **Illegal length:** `load_len`=0, then 1025 → `error`=1 and state stays IDLE in both cases; a following legal `start` clears `error`.
- **Throttled stream and ignored start:** `in_valid` toggling every other cycle with `load_len`=DEPTH → addresses 0..1023 with no gaps or duplicates; a `start` pulse mid-load is ignored.
- **Reset mid-run:** assert reset during RUN → `core_reset`=1 and `mem_we`=0 asynchronously; `busy`=0; `cycle_count`=0.

Source files
------------

// File: rtl/imem_loader.sv
// Program loader and run controller: streams instruction words into instruction memory,
// holds the core in reset while loading, then times the run until the final instruction drains.
module imem_loader #(
   parameter int DEPTH        = 1024,
   parameter int ADDR_W       = 10,
   parameter int DRAIN_CYCLES = 4,
   parameter int MAX_CYCLES   = 100000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   load_len,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_reset,
   input  logic              isLastInstruction,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [31:0]       cycle_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RELEASE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_W    = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_W      = (ADDR_W+1)'(1);
   localparam logic [31:0]     LAST_RUN   = 32'(MAX_CYCLES - 1);
   localparam logic [31:0]     DRAIN_INIT = 32'(DRAIN_CYCLES);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
   logic [31:0]       drain_q, drain_d;
   logic [31:0]       cycle_q, cycle_d;
   logic              in_ready_q, in_ready_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              core_reset_q, core_reset_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      word_cnt_d  = word_cnt_q;
      drain_d     = drain_q;
      cycle_d     = cycle_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      error_d     = error_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               if (load_len == '0 || load_len > DEPTH_W) begin
                  error_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  error_d    = 1'b0;
                  cycle_d    = '0;
                  len_d      = load_len;
                  word_cnt_d = '0;
                  state_d    = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            // in_ready is high for the whole of LOAD, so in_valid alone is the handshake
            if (in_valid) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = word_cnt_q[ADDR_W-1:0];
               mem_wdata_d = in_data;
               word_cnt_d  = word_cnt_q + ONE_W;
               if (word_cnt_q == len_q - ONE_W) begin
                  state_d = S_RELEASE;
               end
            end
         end
         S_RELEASE: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            cycle_d = cycle_q + 32'd1;
            if (isLastInstruction) begin
               drain_d = DRAIN_INIT;
               state_d = S_DRAIN;
            end else if (cycle_d == LAST_RUN) begin
               error_d = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DRAIN: begin
            if (drain_q <= 32'd1) begin
               state_d = S_DONE;
            end else begin
               drain_d = drain_q - 32'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status outputs are registered copies of what the next state implies
      in_ready_d   = (state_d == S_LOAD);
      busy_d       = (state_d == S_LOAD) || (state_d == S_RELEASE) ||
                     (state_d == S_RUN)  || (state_d == S_DRAIN);
      core_reset_d = !((state_d == S_RUN) || (state_d == S_DRAIN));
      done_d       = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         len_q        <= '0;
         word_cnt_q   <= '0;
         drain_q      <= '0;
         cycle_q      <= '0;
         in_ready_q   <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         core_reset_q <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         word_cnt_q   <= word_cnt_d;
         drain_q      <= drain_d;
         cycle_q      <= cycle_d;
         in_ready_q   <= in_ready_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         core_reset_q <= core_reset_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign core_reset  = core_reset_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;
   assign cycle_count = cycle_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: expected writes, run counts and drain timing
// come from a transaction-level model of accepted words and run lengths.
module tb_imem_loader;

   localparam int DEPTH        = 1024;
   localparam int ADDR_W       = 10;
   localparam int DRAIN_CYCLES = 4;
   localparam int MAX_CYCLES   = 100000;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W:0]   load_len = '0;
   logic              in_valid = 1'b0;
   logic [31:0]       in_data = '0;
   logic              isLastInstruction = 1'b0;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              core_reset;
   logic              busy;
   logic              done;
   logic              error;
   logic [31:0]       cycle_count;

   int passCount = 0;
   int checkCount = 0;
   int cyc = 0;

   logic [31:0] words[$];
   logic [31:0] wrAddr[$];
   logic [31:0] wrData[$];
   int          wrCyc[$];
   logic [31:0] expAddr[$];
   logic [31:0] expData[$];
   int          expCyc[$];

   imem_loader #(
      .DEPTH(DEPTH),
      .ADDR_W(ADDR_W),
      .DRAIN_CYCLES(DRAIN_CYCLES),
      .MAX_CYCLES(MAX_CYCLES)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .load_len(load_len),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .core_reset(core_reset),
      .isLastInstruction(isLastInstruction),
      .busy(busy),
      .done(done),
      .error(error),
      .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Every memory write the DUT performs, with the cycle it was seen in
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wrAddr.push_back(32'(mem_addr));
         wrData.push_back(mem_wdata);
         wrCyc.push_back(cyc);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
   endtask

   task automatic fillWords(input int len);
      words.delete();
      for (int i = 0; i < len; i++) words.push_back($urandom);
   endtask

   // Starts a load of words[0..len-1]; mode 0 = back-to-back, 1 = every other cycle, 2 = random gaps.
   // Returns at the first RUN cycle.
   task automatic loadProgram(input int len, input int mode, input bit pokeStart);
      int idx = 0;
      int budget = 0;
      int readyErr = 0;
      int wrErr = 0;
      bit toggle = 1'b1;
      bit offer;
      wrAddr.delete(); wrData.delete(); wrCyc.delete();
      expAddr.delete(); expData.delete(); expCyc.delete();
      @(negedge clk);
      start = 1'b1;
      load_len = (ADDR_W+1)'(len);
      in_valid = 1'b1;
      in_data = 32'hDEADBEEF;
      @(negedge clk);
      start = 1'b0;
      checkOutput("ready_after_start", 32'(in_ready), 1);
      checkOutput("busy_load", 32'(busy), 1);
      checkOutput("error_cleared", 32'(error), 0);
      checkOutput("done_cleared", 32'(done), 0);
      while (idx < len && budget < 3 * len + 20) begin
         case (mode)
            0:       offer = 1'b1;
            1:       offer = toggle;
            default: offer = 1'($urandom_range(0, 1));
         endcase
         toggle = !toggle;
         in_valid = offer;
         in_data = offer ? words[idx] : $urandom;
         isLastInstruction = 1'($urandom_range(0, 1));
         if (pokeStart && idx == len / 2) begin
            start = 1'b1;
            load_len = (ADDR_W+1)'(3);
         end else begin
            start = 1'b0;
         end
         if (in_ready !== 1'b1) readyErr++;
         @(negedge clk);
         budget++;
         if (offer) begin
            expCyc.push_back(cyc);
            expAddr.push_back(32'(idx));
            expData.push_back(words[idx]);
            idx++;
         end
      end
      in_valid = 1'b0;
      start = 1'b0;
      isLastInstruction = 1'b0;
      checkOutput("load_budget", 32'(idx), 32'(len));
      checkOutput("ready_during_load", 32'(readyErr), 0);
      checkOutput("release_ready", 32'(in_ready), 0);
      checkOutput("release_core_reset", 32'(core_reset), 1);
      checkOutput("release_busy", 32'(busy), 1);
      @(negedge clk);
      checkOutput("run_core_reset", 32'(core_reset), 0);
      checkOutput("write_count", 32'(wrAddr.size()), 32'(expAddr.size()));
      for (int i = 0; i < expAddr.size(); i++) begin
         if (i >= wrAddr.size()) wrErr++;
         else if (wrAddr[i] !== expAddr[i] || wrData[i] !== expData[i] || wrCyc[i] != expCyc[i]) wrErr++;
      end
      checkOutput("write_list", 32'(wrErr), 0);
      checkOutput("last_write_addr", (wrAddr.size() > 0) ? wrAddr[wrAddr.size() - 1] : 32'hFFFFFFFF, 32'(len - 1));
   endtask

   // Called at the first RUN cycle; raises isLastInstruction in RUN cycle number runCycles
   task automatic applyRun(input int runCycles);
      bit early = 1'b0;
      for (int i = 1; i <= runCycles; i++) begin
         isLastInstruction = (i == runCycles);
         @(negedge clk);
      end
      isLastInstruction = 1'b0;
      checkOutput("drain_count", cycle_count, 32'(runCycles));
      checkOutput("drain_busy", 32'(busy), 1);
      checkOutput("drain_core_reset", 32'(core_reset), 0);
      for (int d = 0; d < DRAIN_CYCLES; d++) begin
         if (done !== 1'b0) early = 1'b1;
         isLastInstruction = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      isLastInstruction = 1'b0;
      checkOutput("drain_no_early_done", 32'(early), 0);
      checkOutput("done_set", 32'(done), 1);
      checkOutput("done_core_reset", 32'(core_reset), 1);
      checkOutput("done_busy", 32'(busy), 0);
      checkOutput("done_error", 32'(error), 0);
      checkOutput("done_count", cycle_count, 32'(runCycles));
      isLastInstruction = 1'b1;
      @(negedge clk);
      isLastInstruction = 1'b0;
      checkOutput("done_held", 32'(done), 1);
      checkOutput("count_frozen", cycle_count, 32'(runCycles));
   endtask

   task automatic applyStimulus();
      int len;
      // Reset state
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_core_reset", 32'(core_reset), 1);
      checkOutput("rst_in_ready", 32'(in_ready), 0);
      checkOutput("rst_done", 32'(done), 0);
      checkOutput("rst_error", 32'(error), 0);
      checkOutput("rst_count", cycle_count, 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_mem_we", 32'(mem_we), 0);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("idle_core_reset", 32'(core_reset), 1);
      checkOutput("idle_in_ready", 32'(in_ready), 0);

      // Basic load of three fixed words followed by a 10-cycle run
      words.delete();
      words.push_back(32'hA0); words.push_back(32'hB1); words.push_back(32'hC2);
      loadProgram(3, 0, 1'b0);
      applyRun(10);

      // Illegal lengths from DONE and IDLE
      start = 1'b1; load_len = '0;
      @(negedge clk);
      start = 1'b0;
      checkOutput("len0_error", 32'(error), 1);
      checkOutput("len0_done", 32'(done), 0);
      checkOutput("len0_busy", 32'(busy), 0);
      checkOutput("len0_ready", 32'(in_ready), 0);
      start = 1'b1; load_len = (ADDR_W+1)'(DEPTH + 1);
      @(negedge clk);
      start = 1'b0;
      checkOutput("len1025_error", 32'(error), 1);
      checkOutput("len1025_busy", 32'(busy), 0);
      @(negedge clk);
      checkOutput("illegal_stays_idle", 32'(in_ready), 0);
      checkOutput("illegal_core_reset", 32'(core_reset), 1);

      // Random length with random gaps; its start clears the error
      len = $urandom_range(1, 40);
      fillWords(len);
      loadProgram(len, 2, 1'b0);
      applyRun($urandom_range(1, 30));

      // Shortest program and shortest run
      fillWords(1);
      loadProgram(1, 0, 1'b0);
      applyRun(1);

      // Full-depth load, throttled, with a stray start mid-load
      fillWords(DEPTH);
      loadProgram(DEPTH, 1, 1'b1);
      applyRun(5);

      // Reset in the middle of a run
      len = $urandom_range(1, 20);
      fillWords(len);
      loadProgram(len, 0, 1'b0);
      repeat (5) @(negedge clk);
      checkOutput("run_count_progress", cycle_count, 5);
      #2 reset = 1'b0;
      #1;
      checkOutput("midrun_core_reset", 32'(core_reset), 1);
      checkOutput("midrun_mem_we", 32'(mem_we), 0);
      checkOutput("midrun_busy", 32'(busy), 0);
      checkOutput("midrun_count", cycle_count, 0);
      @(negedge clk);
      reset = 1'b1;

      // Reset while a write is in flight
      fillWords(8);
      @(negedge clk);
      start = 1'b1; load_len = (ADDR_W+1)'(8);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = words[i];
         @(negedge clk);
      end
      checkOutput("midload_we_before", 32'(mem_we), 1);
      #2 reset = 1'b0;
      #1;
      checkOutput("midload_mem_we", 32'(mem_we), 0);
      checkOutput("midload_ready", 32'(in_ready), 0);
      checkOutput("midload_core_reset", 32'(core_reset), 1);
      checkOutput("midload_busy", 32'(busy), 0);
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("after_reset_idle", 32'(busy), 0);

      // Recovery after reset
      fillWords(4);
      loadProgram(4, 0, 1'b0);
      applyRun(3);
   endtask

   initial begin
      applyStimulus();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
